// File: rtl/priority_4_2_enc.sv
// Registered 4-to-2 priority encoder with valid flag.
// d[3] has the highest priority. The output index comes from the highest set bit.
// valid is high when any bit was set.
// Both outputs are taken straight from flops, so there is one cycle of latency
// and no combinational path from d to the outputs.
//
// The encoder is an if/else priority chain rather than a full-vector decode.
// Once a higher bit is found set, the lower bits are never examined. This means
// X/Z on those lower bits cannot leak into a or valid in simulation.
//
// a = 00 is returned both for d = 0001 and for d = 0000.
// Consumers must qualify a with valid.
module priority_4_2_enc (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d,
    output logic [1:0] a,
    output logic       valid
);

    logic [1:0] a_d;
    logic [1:0] a_q;
    logic       valid_d;
    logic       valid_q;

    // Priority chain: test the highest bit first, fall through to lower bits.
    always_comb begin
        a_d     = 2'b00;
        valid_d = 1'b0;
        if (d[3]) begin
            a_d     = 2'b11;
            valid_d = 1'b1;
        end else if (d[2]) begin
            a_d     = 2'b10;
            valid_d = 1'b1;
        end else if (d[1]) begin
            a_d     = 2'b01;
            valid_d = 1'b1;
        end else if (d[0]) begin
            a_d     = 2'b00;
            valid_d = 1'b1;
        end
    end

    // Output register. Reset clears it immediately and drops any sampled value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= 2'b00;
            valid_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            valid_q <= valid_d;
        end
    end

    assign a     = a_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_priority_4_2_enc.sv
// Scoreboard bench for priority_4_2_enc.
// The stimulus side drives d on the falling edge and queues the expected result.
// The monitor pops one entry just after each rising edge and compares it.
module tb_priority_4_2_enc;

    logic       clk;
    logic       rst_n;
    logic [3:0] d;
    logic [1:0] a;
    logic       valid;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] din;
        logic [1:0] a;
        logic       v;
    } exp_t;

    exp_t sb_q[$];

    priority_4_2_enc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .a     (a),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the index of the highest bit known to be 1; valid if such a bit exists.
    function automatic exp_t model(input logic [3:0] v);
        exp_t e;
        int   top;
        top = -1;
        for (int i = 0; i < 4; i++)
            if (v[i] === 1'b1) top = i;
        e.din = v;
        e.v   = (top >= 0);
        e.a   = (top >= 0) ? 2'(top) : 2'd0;
        return e;
    endfunction

    task automatic check(input string name, input logic [3:0] din,
                         input logic [1:0] got_a, input logic got_v,
                         input logic [1:0] exp_a, input logic exp_v);
        n_vec++;
        if (got_a !== exp_a || got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s d=%b: got a=%b valid=%b, expected a=%b valid=%b",
                     name, din, got_a, got_v, exp_a, exp_v);
        end
    endtask

    // Drive one input on the falling edge and record its expected response.
    task automatic drive(input logic [3:0] v);
        @(negedge clk);
        d = v;
        sb_q.push_back(model(v));
    endtask

    // Monitor: every rising edge presents a result; compare it against the oldest entry.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("stream", e.din, a, valid, e.a, e.v);
        end
    end

    initial begin
        logic [3:0] v;
        int         top;

        // Reset held with all requests set: outputs must stay cleared.
        rst_n = 1'b0;
        d     = 4'b1111;
        #2;
        check("reset_async", d, a, valid, 2'b00, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_hold", d, a, valid, 2'b00, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back(model(4'b1111));
        #1;
        check("release_hold", d, a, valid, 2'b00, 1'b0);

        // Walk each priority level with the lower bits unknown.
        drive(4'b0001);
        drive(4'b001x);
        drive(4'b01xx);
        drive(4'b1xxx);

        // Empty input versus index-0 input.
        drive(4'b0000);
        drive(4'b0001);
        drive(4'b0000);

        // Exhaustive sweep of all 16 values on consecutive cycles.
        for (int i = 0; i < 16; i++) drive(4'(i));

        // Back-to-back alternation.
        for (int i = 0; i < 6; i++) drive((i % 2 == 0) ? 4'b1000 : 4'b0001);

        // Async reset mid-stream.
        drive(4'b1000);
        drive(4'b0100);
        drive(4'b0010);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_mid", d, a, valid, 2'b00, 1'b0);
        @(negedge clk);
        d     = 4'b0100;
        rst_n = 1'b1;
        sb_q.push_back(model(4'b0100));
        #1;
        check("reset_mid_release", d, a, valid, 2'b00, 1'b0);

        // Randomized inputs; sometimes X is injected below the highest set bit.
        for (int n = 0; n < 200; n++) begin
            v   = 4'($urandom_range(0, 15));
            top = -1;
            for (int i = 0; i < 4; i++)
                if (v[i]) top = i;
            if ($urandom_range(0, 1) == 1)
                for (int i = 0; i < top; i++)
                    if ($urandom_range(0, 1) == 1) v[i] = 1'bx;
            drive(v);
        end

        // Drain with a bounded wait.
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
